// File: rtl/yuv_stream_packer.sv
// yuv_stream_packer: buffers PIXEL_PER_CLK*16-bit YUV422 words from the
// colour-conversion stage and serialises them into OUT_WIDTH-bit beats
// with a valid/ready handshake, marking the final beat of every line.
// Ports:
//   clk_i, reset_n_i        clock (rising edge) and async active-low reset
//   yuv_i, yuv_valid_i      input word and its valid strobe
//   yuv_line_i              high for the whole line
//   dout_o, dout_valid_o    output beat and valid
//   dout_ready_i            sink accepts the beat
//   dout_last_o             final beat of the line (qualified by valid)
//   line_beats_o            beat count of the last completed line
//   overflow_o              sticky input-drop flag, cleared at line start
module yuv_stream_packer #(
  parameter int unsigned PIXEL_PER_CLK = 8,
  parameter int unsigned OUT_WIDTH     = 32,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [PIXEL_PER_CLK*16-1:0]   yuv_i,
  input  logic                          yuv_valid_i,
  input  logic                          yuv_line_i,
  output logic [OUT_WIDTH-1:0]          dout_o,
  output logic                          dout_valid_o,
  input  logic                          dout_ready_i,
  output logic                          dout_last_o,
  output logic [15:0]                   line_beats_o,
  output logic                          overflow_o
);

  localparam int unsigned IN_W = PIXEL_PER_CLK * 16;
  localparam int unsigned NB   = IN_W / OUT_WIDTH;
  localparam int unsigned IW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW   = AW + 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NB - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]      state, state_nxt;
  logic            line_q;
  logic            rise, fall, enter_active;
  logic [IN_W-1:0] stg_data;
  logic            stg_full;
  logic            accept, push_req, push_ok, push_last, drop;
  logic [IN_W-1:0] mem_data [FIFO_DEPTH];
  logic            mem_last [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]   cnt, cnt_after_pop;
  logic            full, hs, pop, avail;
  logic [IW-1:0]   idx, idx_nxt;
  logic [IN_W-1:0] head_word;
  logic [15:0]     beat_cnt, cnt_inc;

  // Line edge detection; the registered copy resets high so a reset released
  // mid-line never looks like a line start.
  assign rise         = yuv_line_i & ~line_q;
  assign fall         = ~yuv_line_i & line_q;
  assign enter_active = (state == ST_IDLE) & rise;

  // Words are only taken inside a line that started after reset.
  assign accept    = yuv_valid_i & ((state == ST_ACTIVE) | rise);
  assign push_req  = stg_full & (accept | fall);
  assign push_last = ~accept;

  assign full    = (cnt == DEPTH_CNT);
  assign hs      = dout_valid_o & dout_ready_i;
  assign pop     = hs & (idx == LAST_IDX);
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  // Next beat to present: head after this cycle's pop, at the advanced index.
  // Only entries present before this edge count, giving one clock of latency.
  assign cnt_after_pop = cnt - CW'(pop);
  assign avail         = (cnt_after_pop != '0);
  assign rd_nxt        = rd_ptr + AW'(pop);
  assign idx_nxt       = hs ? ((idx == LAST_IDX) ? '0 : idx + IW'(1)) : idx;
  assign head_word     = mem_data[rd_nxt];

  assign cnt_inc = (beat_cnt == 16'hFFFF) ? 16'hFFFF : beat_cnt + 16'd1;

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (rise) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (fall) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Line strobe history and staging register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      line_q   <= 1'b1;
      stg_data <= '0;
      stg_full <= 1'b0;
    end else begin
      line_q <= yuv_line_i;
      if (accept) begin
        stg_data <= yuv_i;
        stg_full <= 1'b1;
      end else if (fall) begin
        stg_full <= 1'b0;
      end
    end
  end

  // FIFO storage (data needs no reset; pointers define validity)
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_data[wr_ptr] <= stg_data;
      mem_last[wr_ptr] <= push_last;
    end
  end

  // FIFO pointers, occupancy and beat index
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      idx    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_nxt;
      cnt    <= cnt_after_pop + CW'(push_ok);
      idx    <= idx_nxt;
    end
  end

  // Output beat register; holds while valid and not ready
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dout_o       <= '0;
      dout_valid_o <= 1'b0;
      dout_last_o  <= 1'b0;
    end else if (!dout_valid_o || dout_ready_i) begin
      dout_valid_o <= avail;
      if (avail) begin
        dout_o      <= OUT_WIDTH'(head_word >> (idx_nxt * OUT_WIDTH));
        dout_last_o <= mem_last[rd_nxt] & (idx_nxt == LAST_IDX);
      end else begin
        dout_last_o <= 1'b0;
      end
    end
  end

  // Per-line beat counter and sticky overflow flag
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      beat_cnt     <= '0;
      line_beats_o <= '0;
      overflow_o   <= 1'b0;
    end else begin
      if (hs) begin
        if (dout_last_o) begin
          line_beats_o <= cnt_inc;
          beat_cnt     <= '0;
        end else begin
          beat_cnt <= cnt_inc;
        end
      end
      if (enter_active) overflow_o <= 1'b0;
      if (drop)         overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_yuv_stream_packer.sv
// tb_yuv_stream_packer: self-checking bench for yuv_stream_packer. Input
// words are expanded into an expected beat stream (LSB slice first, last
// flag on the final beat of each line) and compared against every handshake;
// line beat counts and the overflow flag are predicted from the same stream.
module tb_yuv_stream_packer;

  localparam int unsigned PIXEL_PER_CLK = 8;
  localparam int unsigned OUT_WIDTH     = 32;
  localparam int unsigned FIFO_DEPTH    = 4;
  localparam int unsigned IN_W          = PIXEL_PER_CLK * 16;
  localparam int unsigned NB            = IN_W / OUT_WIDTH;

  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic                 last;
  } beat_t;

  logic                 clk_i = 1'b0;
  logic                 reset_n_i;
  logic [IN_W-1:0]      yuv_i;
  logic                 yuv_valid_i;
  logic                 yuv_line_i;
  logic [OUT_WIDTH-1:0] dout_o;
  logic                 dout_valid_o;
  logic                 dout_ready_i;
  logic                 dout_last_o;
  logic [15:0]          line_beats_o;
  logic                 overflow_o;

  int          n_total = 0;
  int          n_bad   = 0;
  int          rmode   = 0;
  beat_t       exp_q[$];
  logic [15:0] m_cnt = '0;
  logic [15:0] m_lb  = '0;

  yuv_stream_packer #(
    .PIXEL_PER_CLK(PIXEL_PER_CLK),
    .OUT_WIDTH    (OUT_WIDTH),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .yuv_i        (yuv_i),
    .yuv_valid_i  (yuv_valid_i),
    .yuv_line_i   (yuv_line_i),
    .dout_o       (dout_o),
    .dout_valid_o (dout_valid_o),
    .dout_ready_i (dout_ready_i),
    .dout_last_o  (dout_last_o),
    .line_beats_o (line_beats_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] make_word(input bit incr, input int i);
    logic [IN_W-1:0] w;
    w = '0;
    for (int b = 0; b < int'(IN_W / 8); b++)
      w[b*8 +: 8] = incr ? 8'(i * int'(IN_W / 8) + b) : 8'($urandom);
    return w;
  endfunction

  // Sink ready pattern: 0 always, 1 toggle, 2 random, 3 held low
  initial begin
    dout_ready_i = 1'b1;
    forever begin
      @(negedge clk_i);
      case (rmode)
        0:       dout_ready_i = 1'b1;
        1:       dout_ready_i = ~dout_ready_i;
        2:       dout_ready_i = 1'($urandom % 2);
        default: dout_ready_i = 1'b0;
      endcase
    end
  end

  // Output monitor / scoreboard
  initial begin
    beat_t                e;
    logic [OUT_WIDTH-1:0] held;
    bit                   stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk_i);
      #1;
      if (reset_n_i !== 1'b1) begin
        stalled = 1'b0;
        continue;
      end
      chk("line_beats", 64'(line_beats_o), 64'(m_lb));
      if (stalled) begin
        chk("hold_valid", 64'(dout_valid_o), 64'd1);
        chk("hold_data", 64'(dout_o), 64'(held));
      end
      stalled = 1'b0;
      if (exp_q.size() == 0) begin
        chk("idle_valid", 64'(dout_valid_o), 64'd0);
      end else if (dout_valid_o === 1'b1) begin
        if (dout_ready_i) begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(dout_o), 64'(e.data));
          chk("beat_last", 64'(dout_last_o), 64'(e.last));
          m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
          if (e.last) begin
            m_lb  = m_cnt;
            m_cnt = '0;
          end
        end else begin
          stalled = 1'b1;
          held    = dout_o;
        end
      end
    end
  end

  task automatic push_beats(input logic [IN_W-1:0] w);
    beat_t e;
    for (int k = 0; k < int'(NB); k++) begin
      e.data = w[k*OUT_WIDTH +: OUT_WIDTH];
      e.last = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // One line of nwords; with stall_all the sink never drains, so only the
  // first FIFO_DEPTH words survive and the rest (including the last) drop.
  task automatic send_line(input int nwords, input bit stall_all, input bit gaps, input bit incr);
    logic [IN_W-1:0] w;
    int guard;
    yuv_line_i = 1'b1;
    @(negedge clk_i);
    chk("ovf_clear", 64'(overflow_o), 64'd0);
    for (int i = 0; i < nwords; i++) begin
      if (!stall_all) begin
        guard = 0;
        while ((exp_q.size() > int'((FIFO_DEPTH - 1) * NB) || (gaps && ($urandom % 3) == 0))
               && guard < 400) begin
          @(negedge clk_i);
          guard++;
        end
        if (guard >= 400) chk("throttle_timeout", 64'(exp_q.size()), 64'd0);
      end
      w           = make_word(incr, i);
      yuv_i       = w;
      yuv_valid_i = 1'b1;
      if (!stall_all || i < int'(FIFO_DEPTH)) push_beats(w);
      @(negedge clk_i);
      yuv_valid_i = 1'b0;
    end
    yuv_line_i = 1'b0;
    if (nwords > 0 && (!stall_all || nwords <= int'(FIFO_DEPTH)))
      exp_q[exp_q.size()-1].last = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(negedge clk_i);
      g++;
    end
    repeat (3) @(negedge clk_i);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nw;
    reset_n_i   = 1'b0;
    yuv_i       = '0;
    yuv_valid_i = 1'b0;
    yuv_line_i  = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_valid", 64'(dout_valid_o), 64'd0);
    chk("rst_data", 64'(dout_o), 64'd0);
    chk("rst_last", 64'(dout_last_o), 64'd0);
    chk("rst_lb", 64'(line_beats_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Single line, 3 incrementing-byte words, ready high
    rmode = 0;
    send_line(3, 1'b0, 1'b0, 1'b1);
    drain();
    chk("t1_lb", 64'(line_beats_o), 64'd12);

    // Same line with ready toggling
    rmode = 1;
    send_line(3, 1'b0, 1'b0, 1'b1);
    drain();
    chk("t2_lb", 64'(line_beats_o), 64'd12);
    chk("t2_ovf", 64'(overflow_o), 64'd0);

    // Back-to-back lines: 2 words, one low cycle, 1 word
    rmode = 0;
    send_line(2, 1'b0, 1'b0, 1'b0);
    send_line(1, 1'b0, 1'b0, 1'b0);
    drain();
    chk("t6_lb", 64'(line_beats_o), 64'd4);

    // 7 words with the sink stalled: 4 buffered, later words dropped
    rmode = 3;
    send_line(7, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk_i);
    chk("t3_ovf_set", 64'(overflow_o), 64'd1);
    rmode = 0;
    drain();
    chk("t3_ovf_hold", 64'(overflow_o), 64'd1);
    chk("t3_lb_keep", 64'(line_beats_o), 64'd4);

    // Empty 5-cycle line: clears overflow, no beats, count unchanged
    yuv_line_i = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("t5_ovf_clear", 64'(overflow_o), 64'd0);
    yuv_line_i = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("t5_no_valid", 64'(dout_valid_o), 64'd0);
    chk("t5_lb_keep", 64'(line_beats_o), 64'd4);

    // Reset mid-line with 2 words buffered and one staged
    rmode = 3;
    yuv_line_i = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      yuv_i       = make_word(1'b0, i);
      yuv_valid_i = 1'b1;
      push_beats(yuv_i);
      @(negedge clk_i);
    end
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(dout_valid_o), 64'd0);
    chk("mid_rst_data", 64'(dout_o), 64'd0);
    chk("mid_rst_lb", 64'(line_beats_o), 64'd0);
    exp_q.delete();
    m_cnt = '0;
    m_lb  = '0;
    rmode = 0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      yuv_i = make_word(1'b0, i);
      @(negedge clk_i);
    end
    yuv_valid_i = 1'b0;
    yuv_line_i  = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("post_rst_quiet", 64'(dout_valid_o), 64'd0);
    send_line(2, 1'b0, 1'b0, 1'b1);
    drain();
    chk("post_rst_lb", 64'(line_beats_o), 64'd8);

    // Randomized lines and sink behaviour
    for (int r = 0; r < 30; r++) begin
      rmode = int'($urandom % 3);
      nw    = int'($urandom % 7);
      send_line(nw, 1'b0, 1'b1, 1'b0);
      if (($urandom % 2) == 0) drain();
    end
    rmode = 0;
    drain();
    chk("rand_ovf", 64'(overflow_o), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
